// File: rtl/ufpgapll_pkg.sv
// ufpgapll_pkg: constants and types shared by the PLL top, the feedback
// conditioner and the display stage.
//   CLK_HZ / FREQ_MIN_HZ  system clock and lowest legal feedback frequency
//   NOSIG_CYCLES_DEF      loss-of-signal timeout: NOSIG_PERIODS slowest periods
//   NS_CTR_W              width of the loss-of-signal counter
//   fb_edge_t             same-cycle "fb_clean is flipping now" indication
package ufpgapll_pkg;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned FREQ_MIN_HZ      = 50_000;
  localparam int unsigned NOSIG_PERIODS    = 5;
  localparam int unsigned NOSIG_CYCLES_DEF = NOSIG_PERIODS * (CLK_HZ / FREQ_MIN_HZ);
  localparam int          NS_CTR_W         = 24;

  // Combinational edge indication: high on the clock edge that will flip
  // fb_clean, i.e. the same edge that registers fb_rise / fb_fall.
  typedef struct packed {
    logic rise;
    logic fall;
  } fb_edge_t;

endpackage

// File: rtl/sync_filter.sv
// sync_filter: two-flop synchroniser for the asynchronous feedback pin,
// followed by a consecutive-sample glitch filter and rise/fall pulse
// generation.
//   clk_50    system clock
//   rst_n     asynchronous active-low reset
//   fb_u      raw asynchronous feedback input
//   fb_clean  filtered level; flips after FILT_LEN disagreeing samples
//   fb_rise   one-cycle pulse, first cycle fb_clean reads 1
//   fb_fall   one-cycle pulse, first cycle fb_clean reads 0
//   edge_now  combinational: fb_clean flips on the coming edge
module sync_filter
  import ufpgapll_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic     clk_50,
  input  logic     rst_n,
  input  logic     fb_u,
  output logic     fb_clean,
  output logic     fb_rise,
  output logic     fb_fall,
  output fb_edge_t edge_now
);

  logic       fb_s0;
  logic       fb_s1;
  logic [3:0] filt_cnt;
  logic       disagree;
  logic       flip;

  assign disagree = (fb_s1 != fb_clean);
  // filt_cnt holds the number of disagreeing samples already seen, so the
  // FILT_LEN-th one arrives while it reads FILT_LEN-1.
  assign flip          = disagree && (filt_cnt == 4'(FILT_LEN - 1));
  assign edge_now.rise = flip &  fb_s1;
  assign edge_now.fall = flip & ~fb_s1;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      fb_s0    <= 1'b0;
      fb_s1    <= 1'b0;
      fb_clean <= 1'b0;
      fb_rise  <= 1'b0;
      fb_fall  <= 1'b0;
      filt_cnt <= 4'd0;
    end else begin
      fb_s0   <= fb_u;
      fb_s1   <= fb_s0;
      fb_rise <= edge_now.rise;
      fb_fall <= edge_now.fall;
      if (flip) begin
        fb_clean <= fb_s1;
        filt_cnt <= 4'd0;
      end else if (disagree) begin
        filt_cnt <= filt_cnt + 4'd1;
      end else begin
        filt_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/fb_conditioner.sv
// fb_conditioner: feedback input conditioning ahead of the PLL phase
// comparator. Synchronises and deglitches fb_u, emits edge pulses, measures
// the rise-to-rise period and flags loss of signal.
//   clk_50        50 MHz system clock
//   rst_n         asynchronous active-low reset
//   fb_u          raw asynchronous feedback input
//   fb_clean      synchronised, glitch-filtered level
//   fb_rise       one-cycle pulse on fb_clean rising
//   fb_fall       one-cycle pulse on fb_clean falling
//   period        last valid rise-to-rise period in clk_50 cycles
//   period_valid  one-cycle strobe when period updates
//   nosig         loss-of-signal flag
module fb_conditioner
  import ufpgapll_pkg::*;
#(
  parameter int          FILT_LEN     = 4,
  parameter int          PERIOD_W     = 16,
  parameter int unsigned NOSIG_CYCLES = NOSIG_CYCLES_DEF
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                fb_u,
  output logic                fb_clean,
  output logic                fb_rise,
  output logic                fb_fall,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                nosig
);

  localparam logic [PERIOD_W-1:0] PER_MAX = '1;
  localparam logic [PERIOD_W-1:0] PER_ONE = PERIOD_W'(1);
  localparam logic [NS_CTR_W-1:0] NS_MAX  = NS_CTR_W'(NOSIG_CYCLES);
  localparam logic [NS_CTR_W-1:0] NS_ONE  = NS_CTR_W'(1);

  fb_edge_t            edge_now;
  logic [PERIOD_W-1:0] per_ctr;
  logic                armed;
  logic [NS_CTR_W-1:0] ns_ctr;
  logic                signal_edge;
  logic                ns_hit;

  sync_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_sync_filter (
    .clk_50  (clk_50),
    .rst_n   (rst_n),
    .fb_u    (fb_u),
    .fb_clean(fb_clean),
    .fb_rise (fb_rise),
    .fb_fall (fb_fall),
    .edge_now(edge_now)
  );

  assign signal_edge = edge_now.rise | edge_now.fall;
  // True on the edge where ns_ctr reaches the timeout.
  assign ns_hit      = (ns_ctr == NS_MAX - NS_ONE);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      per_ctr      <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      ns_ctr       <= '0;
      nosig        <= 1'b1;
    end else begin
      period_valid <= 1'b0;

      // Period measurement. A saturated counter means the gap was too long
      // to represent: drop it, but stay armed for the next period.
      if (edge_now.rise) begin
        if (armed && (per_ctr != PER_MAX)) begin
          period       <= per_ctr + PER_ONE;
          period_valid <= 1'b1;
        end
        per_ctr <= '0;
        armed   <= 1'b1;
      end else begin
        if (per_ctr != PER_MAX) begin
          per_ctr <= per_ctr + PER_ONE;
        end
        if (!signal_edge && ns_hit) begin
          armed <= 1'b0;
        end
      end

      // Loss of signal; a simultaneous signal edge wins over the timeout.
      if (signal_edge) begin
        ns_ctr <= '0;
        nosig  <= 1'b0;
      end else if (ns_hit) begin
        ns_ctr <= NS_MAX;
        nosig  <= 1'b1;
      end else if (ns_ctr != NS_MAX) begin
        ns_ctr <= ns_ctr + NS_ONE;
      end
    end
  end

endmodule
